// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-block instruction cache responder.
// Hits answer in the same cycle; misses fill through one outstanding memory read.
module icache_responder #(
  parameter int unsigned SETS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned IDX  = $clog2(SETS);
  localparam int unsigned TAGW = 30 - IDX;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [SETS-1:0]   r_valid;
  logic [TAGW-1:0]   r_tag  [SETS];
  logic [31:0]       r_data [SETS];
  logic [31:0]       r_miss_addr;
  logic [31:0]       r_hit_count;
  logic [31:0]       r_miss_count;

  logic [IDX-1:0]    w_idx;
  logic [TAGW-1:0]   w_tag;
  logic [IDX-1:0]    w_fill_idx;
  logic [TAGW-1:0]   w_fill_tag;
  logic              w_lookup;
  logic              w_miss_start;
  logic              w_fill;

  assign w_idx      = imemaddr[IDX+1:2];
  assign w_tag      = imemaddr[31:IDX+2];
  assign w_fill_idx = r_miss_addr[IDX+1:2];
  assign w_fill_tag = r_miss_addr[31:IDX+2];
  assign w_lookup   = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

  always_comb begin
    w_next       = r_state;
    ihit         = 1'b0;
    imemload     = '0;
    iREN         = 1'b0;
    iaddr        = '0;
    w_miss_start = 1'b0;
    w_fill       = 1'b0;
    case (r_state)
      IDLE: begin
        if (imemREN) begin
          if (w_lookup) begin
            ihit     = 1'b1;
            imemload = r_data[w_idx];
          end else begin
            w_miss_start = 1'b1;
            w_next       = FETCH;
          end
        end
      end
      FETCH: begin
        // The fill always completes for the latched address, whatever the PC does.
        iREN  = 1'b1;
        iaddr = r_miss_addr;
        if (!iwait) begin
          w_fill = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= IDLE;
      r_valid      <= '0;
      r_miss_addr  <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_miss_start) begin
        r_miss_addr <= imemaddr & 32'hFFFF_FFFC;
        if (r_miss_count != '1) r_miss_count <= r_miss_count + 32'd1;
      end
      if (ihit && r_hit_count != '1) r_hit_count <= r_hit_count + 32'd1;
      if (w_fill) r_valid[w_fill_idx] <= 1'b1;
    end
  end

  // Tag/data storage carries no reset; the valid bits alone qualify it.
  always_ff @(posedge CLK) begin
    if (w_fill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// Bench for icache_responder: directed scenarios with literal expectations,
// then random fetch traffic checked every cycle against a behavioural cache model.
module tb_icache_responder;

  localparam int unsigned SETS = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = '0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait = 1'b1;
  logic [31:0] iload = '0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  icache_responder #(.SETS(SETS)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h2001_0005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a table of remembered word addresses per set, one pending fill.
  bit          m_busy;
  logic [31:0] m_pend;
  bit          m_valid [SETS];
  logic [29:0] m_word  [SETS];
  logic [31:0] m_data  [SETS];
  logic [31:0] m_hits;
  logic [31:0] m_misses;

  function automatic int set_of(input logic [31:0] a);
    return int'((a >> 2) % SETS);
  endfunction

  function automatic bit model_hit();
    int s;
    s = set_of(imemaddr);
    return !m_busy && imemREN && m_valid[s] && (m_word[s] == imemaddr[31:2]);
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      m_busy   <= 1'b0;
      m_pend   <= '0;
      m_hits   <= '0;
      m_misses <= '0;
      for (int i = 0; i < SETS; i++) m_valid[i] <= 1'b0;
    end else if (!m_busy) begin
      if (model_hit()) begin
        if (m_hits != 32'hFFFF_FFFF) m_hits <= m_hits + 1;
      end else if (imemREN) begin
        m_busy <= 1'b1;
        m_pend <= {imemaddr[31:2], 2'b00};
        if (m_misses != 32'hFFFF_FFFF) m_misses <= m_misses + 1;
      end
    end else if (!iwait) begin
      m_valid[set_of(m_pend)] <= 1'b1;
      m_word[set_of(m_pend)]  <= m_pend[31:2];
      m_data[set_of(m_pend)]  <= memfn(m_pend);
      m_busy                  <= 1'b0;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("ihit", {31'd0, ihit}, {31'd0, model_hit()});
      check("imemload", imemload, model_hit() ? m_data[set_of(imemaddr)] : 32'h0);
      check("iREN", {31'd0, iREN}, {31'd0, m_busy});
      if (m_busy) check("iaddr", iaddr, m_pend);
      check("hit_count", hit_count, m_hits);
      check("miss_count", miss_count, m_misses);
    end
  end

  // Drive one cycle's inputs just after the edge; return shortly after the next falling edge.
  task automatic tick(input logic ren, input logic [31:0] a, input logic w);
    @(posedge CLK);
    #1;
    imemREN  = ren;
    imemaddr = a;
    iwait    = w;
    iload    = w ? $urandom : memfn(m_pend);
    @(negedge CLK);
    #1;
  endtask

  int ren_high;

  initial begin
    // Reset with a request already presented.
    RST = 1'b1; imemREN = 1'b1; imemaddr = 32'h40;
    repeat (2) @(posedge CLK);
    #2;
    check("rst_ihit", {31'd0, ihit}, 32'd0);
    check("rst_iREN", {31'd0, iREN}, 32'd0);
    check("rst_iaddr", iaddr, 32'd0);
    check("rst_imemload", imemload, 32'd0);
    check("rst_hit_count", hit_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
    imemREN = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    #1 chk_en = 1'b1;

    // First miss on 0x40, three wait cycles.
    tick(1'b1, 32'h40, 1'b1);
    check("miss0_ihit", {31'd0, ihit}, 32'd0);
    check("miss0_iREN", {31'd0, iREN}, 32'd0);
    ren_high = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 32'h40, (i == 3) ? 1'b0 : 1'b1);
      if (i == 0) begin
        check("miss1_iaddr", iaddr, 32'h40);
        check("miss1_count", miss_count, 32'd1);
      end
      if (iREN) ren_high++;
    end
    tick(1'b1, 32'h40, 1'b1);
    check("iren_cycles", ren_high, 32'd4);
    check("fill_ihit", {31'd0, ihit}, 32'd1);
    check("fill_data", imemload, 32'h2001_0005);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 32'h40, 1'b1);
      if (i == 0) check("hit_count_1", hit_count, 32'd1);
      check("rehit_ihit", {31'd0, ihit}, 32'd1);
      check("rehit_iREN", {31'd0, iREN}, 32'd0);
    end
    tick(1'b0, 32'h40, 1'b1);
    check("hit_count_6", hit_count, 32'd6);
    check("miss_count_1", miss_count, 32'd1);

    // Same-index conflict: 0x80 evicts 0x40.
    tick(1'b1, 32'h80, 1'b1);
    check("conf_ihit80", {31'd0, ihit}, 32'd0);
    tick(1'b0, 32'h80, 1'b0);
    tick(1'b1, 32'h40, 1'b1);
    check("conf_ihit40", {31'd0, ihit}, 32'd0);
    tick(1'b1, 32'h40, 1'b0);
    tick(1'b1, 32'h40, 1'b1);
    check("conf_final_hit", {31'd0, ihit}, 32'd1);
    check("conf_final_data", imemload, 32'h2001_0005);
    check("conf_miss_count", miss_count, 32'd3);

    // PC changes mid-fetch; fill still completes for 0x100.
    tick(1'b1, 32'h100, 1'b1);
    tick(1'b1, 32'h200, 1'b1);
    check("flush_iaddr", iaddr, 32'h100);
    tick(1'b0, 32'h200, 1'b1);
    tick(1'b1, 32'h200, 1'b0);
    check("flush_iaddr2", iaddr, 32'h100);
    tick(1'b1, 32'h100, 1'b1);
    check("flush_hit100", {31'd0, ihit}, 32'd1);
    check("flush_data100", imemload, memfn(32'h100));
    tick(1'b1, 32'h200, 1'b1);
    check("flush_miss200", {31'd0, ihit}, 32'd0);
    tick(1'b1, 32'h200, 1'b0);
    check("flush_iaddr200", iaddr, 32'h200);
    tick(1'b1, 32'h200, 1'b1);
    check("flush_hit200", {31'd0, ihit}, 32'd1);

    // Reset pulse in the middle of a fetch.
    tick(1'b1, 32'h300, 1'b1);
    tick(1'b0, 32'h300, 1'b1);
    check("pre_rst_iREN", {31'd0, iREN}, 32'd1);
    chk_en = 1'b0;
    RST = 1'b1;
    #1;
    check("async_rst_iREN", {31'd0, iREN}, 32'd0);
    @(posedge CLK);
    #1;
    check("rst2_miss_count", miss_count, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1 chk_en = 1'b1;
    tick(1'b1, 32'h40, 1'b1);
    check("post_rst_miss40", {31'd0, ihit}, 32'd0);
    tick(1'b1, 32'h40, 1'b0);
    check("post_rst_iaddr", iaddr, 32'h40);

    // Random traffic over a small address pool to force hits and conflicts.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      a = ({26'd0, 6'($urandom_range(0, 47))} << 2)
          | (32'($urandom_range(0, 1)) << 12)
          | 32'($urandom_range(0, 3));
      tick(($urandom_range(0, 3) != 0), a, ($urandom_range(0, 1) == 1));
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
